// File: rtl/character_move_ctl.sv
`default_nettype none
// ============================================================================
// Module   : character_move_ctl
// Purpose  : Player-character movement engine. Converts held direction keys
//            into per-frame position updates. It handles walking, following
//            ramp slopes, climbing ladders between min/max limits, and falling
//            off ramp ends down to a landing row.
// Ports    : clk, rst (async, active-high)
//            frame_tick_i              - one-cycle movement strobe per frame
//            key_{left,right,up,down}_i - held direction keys
//            key_jump_i                - jump request (CHARACTER_JUMP_EN only)
//            ladder_i, ramp_i[1:0]     - geometry from the ladder-control block
//            limit_ypos_{min,max}_i    - ladder top/bottom rows
//            end_of_ramp_i, landing_ypos_i - ramp edge and row to fall to
//            xpos_o, ypos_o, state_o, dir_o - registered character state
// Config   : `define CHARACTER_JUMP_EN adds the JUMP state (state_o = 11)
// Revision : 1.0 - initial release
// ============================================================================
module character_move_ctl #(
  parameter int X_INIT      = 0,
  parameter int Y_INIT      = 644,
  parameter int X_MAX       = 976,
  parameter int WALK_STEP   = 2,
  parameter int CLIMB_STEP  = 2,
  parameter int FALL_STEP   = 4,
  parameter int RAMP_PERIOD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick_i,
  input  logic        key_left_i,
  input  logic        key_right_i,
  input  logic        key_up_i,
  input  logic        key_down_i,
  input  logic        key_jump_i,
  input  logic        ladder_i,
  input  logic [1:0]  ramp_i,
  input  logic [11:0] limit_ypos_min_i,
  input  logic [11:0] limit_ypos_max_i,
  input  logic        end_of_ramp_i,
  input  logic [11:0] landing_ypos_i,
  output logic [11:0] xpos_o,
  output logic [11:0] ypos_o,
  output logic [1:0]  state_o,
  output logic        dir_o
);

  localparam int               CNT_W       = (RAMP_PERIOD > 1) ? $clog2(RAMP_PERIOD) : 1;
  localparam logic [12:0]      C_X_MAX     = 13'(X_MAX);
  localparam logic [12:0]      C_WALK      = 13'(WALK_STEP);
  localparam logic [12:0]      C_CLIMB     = 13'(CLIMB_STEP);
  localparam logic [12:0]      C_FALL      = 13'(FALL_STEP);
  localparam logic [CNT_W-1:0] C_RAMP_LAST = CNT_W'(RAMP_PERIOD - 1);

`ifdef CHARACTER_JUMP_EN
  localparam logic [11:0] C_JUMP_STEP = 12'd4;
  localparam logic [2:0]  C_JUMP_LAST = 3'd7;   // 8 rising ticks
  typedef enum logic [1:0] {
    ST_WALK  = 2'b00,
    ST_CLIMB = 2'b01,
    ST_FALL  = 2'b10,
    ST_JUMP  = 2'b11
  } state_t;
  logic [2:0] jump_cnt_q, jump_cnt_d;
`else
  typedef enum logic [1:0] {
    ST_WALK  = 2'b00,
    ST_CLIMB = 2'b01,
    ST_FALL  = 2'b10
  } state_t;
  logic unused_jump;
  assign unused_jump = key_jump_i;
`endif

  state_t           state_q, state_d;
  logic [11:0]      xpos_q, xpos_d, ypos_q, ypos_d, landing_q, landing_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] ramp_cnt_q, ramp_cnt_d;

  // Candidate positions; all arithmetic widened to 13 bits so it saturates.
  logic [12:0] x_ext, y_ext, x_right_sum, y_up_floor, y_down_sum, y_fall_sum;
  logic [11:0] x_walk, y_up, y_down, y_climb, y_ramp_up, y_ramp_dn;
  logic        walk_one, walk_moved, ladder_enter, edge_fall, ramp_inc;

  always_comb begin
    x_ext       = {1'b0, xpos_q};
    y_ext       = {1'b0, ypos_q};
    walk_one    = key_left_i ^ key_right_i;
    x_right_sum = x_ext + C_WALK;
    if (key_right_i) begin
      x_walk = (x_right_sum > C_X_MAX) ? C_X_MAX[11:0] : x_right_sum[11:0];
    end else begin
      x_walk = (x_ext < C_WALK) ? 12'd0 : 12'(x_ext - C_WALK);
    end
    walk_moved = walk_one && (x_walk != xpos_q);

    y_up_floor = {1'b0, limit_ypos_min_i} + C_CLIMB;
    y_up       = (y_ext < y_up_floor) ? limit_ypos_min_i : 12'(y_ext - C_CLIMB);
    y_down_sum = y_ext + C_CLIMB;
    y_down     = (y_down_sum > {1'b0, limit_ypos_max_i}) ? limit_ypos_max_i : y_down_sum[11:0];
    y_climb    = ypos_q;
    if (key_up_i ^ key_down_i) begin
      y_climb = key_up_i ? y_up : y_down;
    end
    y_fall_sum = y_ext + C_FALL;

    y_ramp_up = (&ypos_q) ? ypos_q : ypos_q + 12'd1;
    y_ramp_dn = (ypos_q == 12'd0) ? 12'd0 : ypos_q - 12'd1;
    // 01 descends to the right (screen y grows), 10 descends to the left.
    ramp_inc  = (ramp_i == 2'b01) ? key_right_i : key_left_i;

    ladder_enter = ladder_i && ((key_up_i && (ypos_q > limit_ypos_min_i)) ||
                                (key_down_i && (ypos_q < limit_ypos_max_i)));
    // The edge being stood on is the one on the same half of the screen.
    edge_fall    = end_of_ramp_i && ((xpos_q >= 12'd512) ? key_right_i : key_left_i);
  end

  always_comb begin
    state_d    = state_q;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    dir_d      = dir_q;
    landing_d  = landing_q;
    ramp_cnt_d = ramp_cnt_q;
`ifdef CHARACTER_JUMP_EN
    jump_cnt_d = jump_cnt_q;
`endif
    case (state_q)
      ST_WALK: begin
        if (ramp_i == 2'b00) begin
          ramp_cnt_d = '0;
        end
        if (ladder_enter) begin
          state_d = ST_CLIMB;
        end else if (edge_fall) begin
          landing_d = landing_ypos_i;
          state_d   = ST_FALL;
`ifdef CHARACTER_JUMP_EN
        end else if (key_jump_i) begin
          landing_d  = ypos_q;
          jump_cnt_d = 3'd0;
          state_d    = ST_JUMP;
`endif
        end else if (walk_one) begin
          xpos_d = x_walk;
          dir_d  = key_right_i;
          // Only steps that really moved count; a wall-blocked step leaves
          // both the slope phase and ypos alone.
          if (walk_moved && ((ramp_i == 2'b01) || (ramp_i == 2'b10))) begin
            if (ramp_cnt_q == C_RAMP_LAST) begin
              ramp_cnt_d = '0;
              ypos_d     = ramp_inc ? y_ramp_up : y_ramp_dn;
            end else begin
              ramp_cnt_d = ramp_cnt_q + 1'b1;
            end
          end
        end
      end
      ST_CLIMB: begin
        // ladder_i lags a cycle behind ypos, so exit is decided by the limits.
        ypos_d = y_climb;
        if ((y_climb == limit_ypos_min_i) || (y_climb == limit_ypos_max_i)) begin
          state_d = ST_WALK;
        end
      end
      ST_FALL: begin
        if (y_fall_sum >= {1'b0, landing_q}) begin
          ypos_d  = landing_q;
          state_d = ST_WALK;
        end else begin
          ypos_d = y_fall_sum[11:0];
        end
      end
`ifdef CHARACTER_JUMP_EN
      ST_JUMP: begin
        ypos_d = (ypos_q < C_JUMP_STEP) ? 12'd0 : ypos_q - C_JUMP_STEP;
        if (walk_one) begin
          xpos_d = x_walk;
          dir_d  = key_right_i;
        end
        if (jump_cnt_q == C_JUMP_LAST) begin
          state_d = ST_FALL;
        end else begin
          jump_cnt_d = jump_cnt_q + 3'd1;
        end
      end
`endif
      default: state_d = ST_WALK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_WALK;
      xpos_q     <= 12'(X_INIT);
      ypos_q     <= 12'(Y_INIT);
      dir_q      <= 1'b1;
      landing_q  <= 12'd0;
      ramp_cnt_q <= '0;
`ifdef CHARACTER_JUMP_EN
      jump_cnt_q <= 3'd0;
`endif
    end else if (frame_tick_i) begin
      state_q    <= state_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      dir_q      <= dir_d;
      landing_q  <= landing_d;
      ramp_cnt_q <= ramp_cnt_d;
`ifdef CHARACTER_JUMP_EN
      jump_cnt_q <= jump_cnt_d;
`endif
    end
  end

  assign xpos_o  = xpos_q;
  assign ypos_o  = ypos_q;
  assign state_o = state_q;
  assign dir_o   = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_character_move_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_character_move_ctl
// Purpose  : Self-checking bench for character_move_ctl. Expected outputs are
//            queued as each frame tick is driven and popped once it lands.
//            A second instance with X_INIT=975 covers the odd-x saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_character_move_ctl;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [1:0]  st;
    logic        d;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0;
  logic        key_jump = 1'b0, ladder = 1'b0, end_of_ramp = 1'b0;
  logic [1:0]  ramp = 2'b00;
  logic [11:0] lim_min = 12'd0, lim_max = 12'd0, landing = 12'd0;
  logic [11:0] xpos, ypos, xpos_b, ypos_b;
  logic [1:0]  state, state_b;
  logic        dir, dir_b;

  int   n_vec = 0;
  int   n_err = 0;
  obs_t sb[$];
  obs_t exp_v, got;

  always #5 clk = ~clk;

  character_move_ctl u_dut (
    .clk(clk), .rst(rst), .frame_tick_i(frame_tick),
    .key_left_i(key_left), .key_right_i(key_right), .key_up_i(key_up),
    .key_down_i(key_down), .key_jump_i(key_jump), .ladder_i(ladder),
    .ramp_i(ramp), .limit_ypos_min_i(lim_min), .limit_ypos_max_i(lim_max),
    .end_of_ramp_i(end_of_ramp), .landing_ypos_i(landing),
    .xpos_o(xpos), .ypos_o(ypos), .state_o(state), .dir_o(dir)
  );

  character_move_ctl #(.X_INIT(975)) u_dut_odd (
    .clk(clk), .rst(rst), .frame_tick_i(frame_tick),
    .key_left_i(key_left), .key_right_i(key_right), .key_up_i(key_up),
    .key_down_i(key_down), .key_jump_i(key_jump), .ladder_i(ladder),
    .ramp_i(ramp), .limit_ypos_min_i(lim_min), .limit_ypos_max_i(lim_max),
    .end_of_ramp_i(end_of_ramp), .landing_ypos_i(landing),
    .xpos_o(xpos_b), .ypos_o(ypos_b), .state_o(state_b), .dir_o(dir_b)
  );

  function automatic obs_t mk(int x, int y, int s, int d);
    return obs_t'({12'(x), 12'(y), 2'(s), 1'(d)});
  endfunction

  function automatic obs_t obs_main();
    return obs_t'({xpos, ypos, state, dir});
  endfunction

  function automatic obs_t obs_odd();
    return obs_t'({xpos_b, ypos_b, state_b, dir_b});
  endfunction

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic clear_inputs();
    {key_left, key_right, key_up, key_down, key_jump, ladder, end_of_ramp} = '0;
    ramp = 2'b00;
  endtask

  task automatic do_reset();
    clear_inputs();
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Positions ypos by climbing from the floor row to the requested row.
  task automatic climb_to(input int target);
    ladder = 1'b1; lim_min = 12'(target); lim_max = 12'd644; key_up = 1'b1;
    repeat (1 + (644 - target) / 2) tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    sb.push_back(mk(0, 644, 0, 1));
    exp_v = sb.pop_front(); got = obs_main(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL reset got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
    sb.push_back(mk(975, 644, 0, 1));
    exp_v = sb.pop_front(); got = obs_odd(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL reset_odd got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
  endtask

  task automatic test_walk();
    logic [1:0] keys [4] = '{2'b10, 2'b11, 2'b00, 2'b01};  // {left,right}
    int         ex   [4] = '{18, 18, 18, 20};
    int         ed   [4] = '{0, 0, 0, 1};
    do_reset();
    key_right = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      sb.push_back(mk(2 * i, 644, 0, 1));
      tick();
      exp_v = sb.pop_front(); got = obs_main(); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL walk[%0d] got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", i, got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
    end
    // Keys still held but no frame tick: nothing may move.
    sb.push_back(mk(20, 644, 0, 1));
    repeat (4) @(posedge clk);
    #1;
    exp_v = sb.pop_front(); got = obs_main(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL no_tick_hold got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
    for (int i = 0; i < 4; i++) begin
      {key_left, key_right} = keys[i];
      sb.push_back(mk(ex[i], 644, 0, ed[i]));
      tick();
      exp_v = sb.pop_front(); got = obs_main(); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL walk_keys[%0d] got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", i, got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    key_right = 1'b1;
    sb.push_back(mk(976, 644, 0, 1));
    tick();
    exp_v = sb.pop_front(); got = obs_odd(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL sat_975 got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
    key_left = 1'b1;
    sb.push_back(mk(976, 644, 0, 1));
    tick();
    exp_v = sb.pop_front(); got = obs_odd(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL sat_both got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
    // Main instance is at x=2: two left ticks must clamp at 0.
    key_right = 1'b0;
    repeat (2) tick();
    sb.push_back(mk(0, 644, 0, 0));
    exp_v = sb.pop_front(); got = obs_main(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL sat_left got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
    key_left = 1'b0; key_right = 1'b1;
    repeat (495) tick();
    sb.push_back(mk(976, 644, 0, 1));
    exp_v = sb.pop_front(); got = obs_main(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL sat_right got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
  endtask

  task automatic test_ramp();
    do_reset();
    climb_to(300);
    ramp = 2'b01; key_right = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      if (i == 17) ramp = 2'b10;
      // One pixel of slope per 8 moving steps, down then back up.
      sb.push_back(mk(2 * i, (i <= 16) ? 300 + i / 8 : 302 - (i - 16) / 8, 0, 1));
      tick();
      exp_v = sb.pop_front(); got = obs_main(); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL ramp[%0d] got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", i, got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
    end
  endtask

  task automatic test_ladder();
    do_reset();
    ladder = 1'b1; lim_min = 12'd500; lim_max = 12'd644; key_up = 1'b1;
    key_right = 1'b1;  // must be ignored while climbing
    for (int i = 0; i <= 72; i++) begin
      sb.push_back(mk(0, 644 - 2 * i, (i == 72) ? 0 : 1, 1));
      tick();
      exp_v = sb.pop_front(); got = obs_main(); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL climb_a[%0d] got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", i, got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
    end
    key_right = 1'b0;
    // Already at the top limit: up must not re-enter the ladder.
    sb.push_back(mk(0, 500, 0, 1));
    tick();
    exp_v = sb.pop_front(); got = obs_main(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL climb_at_min got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
    lim_min = 12'd400; lim_max = 12'd500;
    for (int i = 0; i <= 50; i++) begin
      sb.push_back(mk(0, 500 - 2 * i, (i == 50) ? 0 : 1, 1));
      tick();
      exp_v = sb.pop_front(); got = obs_main(); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL climb_b[%0d] got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", i, got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
    end
    key_up = 1'b0; key_down = 1'b1;
    repeat (6) tick();  // entry + 5 steps down to 410
    sb.push_back(mk(0, 410, 1, 1));
    exp_v = sb.pop_front(); got = obs_main(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL climb_down got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    sb.push_back(mk(0, 644, 0, 1));
    exp_v = sb.pop_front(); got = obs_main(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL async_rst got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
    @(posedge clk);
    #1 rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_fall();
    do_reset();
    key_right = 1'b1;
    repeat (20) tick();
    key_right = 1'b0;
    climb_to(290);
    end_of_ramp = 1'b1; landing = 12'd479; key_left = 1'b1;
    for (int i = 0; i <= 48; i++) begin
      if (i == 1) end_of_ramp = 1'b0;
      if (i == 5) landing = 12'd100;  // latched value must win
      sb.push_back(mk(40, (i < 48) ? 290 + 4 * i : 479, (i < 48) ? 2 : 0, 1));
      tick();
      exp_v = sb.pop_front(); got = obs_main(); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL fall[%0d] got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", i, got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
    end
    // Left-half edge with the right key held is just a walk.
    key_left = 1'b0; key_right = 1'b1; end_of_ramp = 1'b1;
    sb.push_back(mk(42, 479, 0, 1));
    tick();
    exp_v = sb.pop_front(); got = obs_main(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL edge_wrong_key got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
    clear_inputs();
  endtask

  task automatic test_jump();
    do_reset();
    key_jump = 1'b1;
`ifdef CHARACTER_JUMP_EN
    for (int i = 0; i <= 16; i++) begin
      if (i == 1) key_jump = 1'b0;
      if (i == 0)       sb.push_back(mk(0, 644, 3, 1));
      else if (i < 8)   sb.push_back(mk(0, 644 - 4 * i, 3, 1));
      else if (i == 8)  sb.push_back(mk(0, 612, 2, 1));
      else if (i < 16)  sb.push_back(mk(0, 612 + 4 * (i - 8), 2, 1));
      else              sb.push_back(mk(0, 644, 0, 1));
      tick();
      exp_v = sb.pop_front(); got = obs_main(); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL jump[%0d] got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", i, got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
    end
`else
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(0, 644, 0, 1));
      tick();
      exp_v = sb.pop_front(); got = obs_main(); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL jump_off[%0d] got x=%0d y=%0d st=%0d dir=%0d want x=%0d y=%0d st=%0d dir=%0d", i, got.x, got.y, got.st, got.d, exp_v.x, exp_v.y, exp_v.st, exp_v.d); end
    end
`endif
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_walk();
    test_saturation();
    test_ramp();
    test_ladder();
    test_fall();
    test_jump();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/character_move_ctl.md
Name: character_move_ctl

Overview:
- Player-character movement engine. It is the consumer of the ladder/ramp/landing geometry produced by the map ladder-control block, and the producer of the `xpos`/`ypos` that block reads back.
- Converts held direction keys into per-frame position updates: walking, ramp slope following, ladder climbing with min/max clamping, and falling off ramp ends to a landing row.
- Sits between the keyboard decoder and the character draw / ladder-control blocks.

Parameters:
- X_INIT, 0: xpos after reset.
- Y_INIT, 644: ypos after reset (bottom floor row).
- X_MAX, 976: maximum xpos (HOR_PIXELS − character width).
- WALK_STEP, 2: pixels per tick horizontally.
- CLIMB_STEP, 2: pixels per tick on a ladder.
- FALL_STEP, 4: pixels per tick while falling.
- RAMP_PERIOD, 8: horizontal steps per 1-pixel vertical ramp adjustment.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle movement strobe (once per frame)
- key_left  in  1  left held
- key_right  in  1  right held
- key_up  in  1  up held
- key_down  in  1  down held
- key_jump  in  1  jump request (used only with CHARACTER_JUMP_EN)
- ladder  in  1  character overlaps a ladder zone
- ramp  in  2  00 flat, 01 descends to the right, 10 descends to the left
- limit_ypos_min  in  12  ladder top ypos
- limit_ypos_max  in  12  ladder bottom ypos
- end_of_ramp  in  1  character is at a ramp edge
- landing_ypos  in  12  target ypos after falling off that edge
- xpos  out  12  character x
- ypos  out  12  character y
- state  out  2  00 WALK, 01 CLIMB, 10 FALL, 11 JUMP
- dir  out  1  facing direction: 1 right, 0 left

Behaviour:
- Reset (async, any time, including mid-climb or mid-fall): `xpos`=X_INIT, `ypos`=Y_INIT, `state`=WALK, `dir`=1, ramp counter=0, latched landing=0. Outputs are registered.
- All updates happen only on the rising edge where `frame_tick`=1; otherwise all registers hold. Outputs change 1 cycle after the tick.

WALK:
- Priority: ladder entry, then edge fall, then horizontal move.
- Ladder entry: `ladder`=1 and ((`key_up` and `ypos` > `limit_ypos_min`) or (`key_down` and `ypos` < `limit_ypos_max`)). Go to CLIMB. Position is unchanged on the entry tick.
- Edge fall: `end_of_ramp`=1 and the key in the direction of the edge is held (right if `xpos` ≥ 512, else left). Latch `landing_ypos` and go to FALL.
- Horizontal move: exactly one of `key_left`/`key_right` held.
  - `xpos` ± WALK_STEP, saturating at 0 and X_MAX; `dir` updated.
  - Both or neither held: no move, `dir` held.
- Ramp following:
  - On each horizontal step that actually moves `xpos` with `ramp`≠00, increment the ramp counter.
  - When the counter reaches RAMP_PERIOD−1 it wraps to 0 and `ypos` adjusts by 1.
  - `ramp`=01: +1 moving right, −1 moving left. `ramp`=10: the reverse.
  - `ramp`=00 clears the counter.

CLIMB:
- `key_up`: `ypos` −= CLIMB_STEP, clamped to ≥ `limit_ypos_min`.
- `key_down`: `ypos` += CLIMB_STEP, clamped to ≤ `limit_ypos_max`.
- Both or neither held: hold.
- Left/right ignored; `xpos` frozen.
- On the same tick, if the resulting `ypos` equals either limit, go to WALK.
- `ladder` is not sampled in CLIMB (it lags one cycle).

FALL:
- `ypos` += FALL_STEP each tick. Once `ypos` + FALL_STEP ≥ latched landing, set `ypos` = landing and go to WALK.
- Keys ignored.
- Arithmetic is unsigned 12-bit computed in 13 bits; saturate, never wrap.

Optional Feature:
- Macro: CHARACTER_JUMP_EN.
- Enabled:
  - In WALK, `key_jump` has lowest priority after ladder entry and edge fall.
  - It latches `ypos` as landing and enters JUMP.
  - JUMP: `ypos` −= 4 for 8 ticks, horizontal moves still allowed without ramp adjustment, then go to FALL with the latched landing.
- Disabled: `key_jump` is ignored, `state` never equals 11, and no JUMP logic is synthesised.

Test Plan:
- Reset with X_INIT=0, Y_INIT=644; 10 ticks holding `key_right`, `ramp`=00 → `xpos`=20, `ypos`=644, `dir`=1, `state`=00.
- Start at `xpos`=975, hold `key_right` for 1 tick → `xpos`=976 (saturated); hold `key_left` and `key_right` together → no change.
- `ramp`=01, hold `key_right` for 16 ticks from `ypos`=300 → `ypos`=302, `xpos` +32. Then `ramp`=10 with the same stimulus → `ypos` back to 300.
- `ladder`=1, `limit_ypos_min`=400, `limit_ypos_max`=500, `ypos`=500, hold `key_up` → entry tick gives `state`=01 and `ypos`=500; after 50 further ticks `ypos`=400 and `state`=00. Assert `rst` mid-climb → immediate reset values.
- `end_of_ramp`=1, `landing_ypos`=479, `ypos`=290, `xpos`=40, hold `key_left` → FALL; `ypos` steps by 4 per tick, ends at exactly 479, then `state`=00. A `landing_ypos` change mid-fall has no effect.
- CHARACTER_JUMP_EN defined, `key_jump` from `ypos`=644 → min `ypos`=612 after 8 ticks, then FALL back to 644. Macro undefined → `key_jump` produces no change.
